// File: rtl/mac_pipe_real_pkg.sv
// Shared mode encodings and fixed-point helpers for the multi-lane MAC pipeline.
// Pure constants and functions; no latency and no flow control.
package mac_pipe_real_pkg;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_ACC = 1'b1;

  function automatic logic signed [63:0] sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

  // Positive result means shift left into the output format, negative means shift right.
  function automatic int align_shift(input int a_exp, input int b_exp, input int c_exp);
    return (a_exp + b_exp) - c_exp;
  endfunction

endpackage

// File: rtl/mac_pipe_real_align_sat.sv
// One lane: align a full-precision product, optionally add the accumulator, saturate.
// Purely combinational (zero latency); no flow control.
module real_align_sat
  import mac_pipe_real_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int SHIFT = -4,
  parameter int OUT_W = 24
) (
  input  logic signed [IN_W-1:0]  prod,
  input  logic signed [OUT_W-1:0] acc,
  input  logic                    add_acc,
  output logic signed [OUT_W-1:0] res,
  output logic                    hit
);

  localparam int LSH  = (SHIFT > 0) ? SHIFT : 0;
  localparam int RSH  = (SHIFT < 0) ? -SHIFT : 0;
  localparam int BASE = (IN_W + LSH > OUT_W) ? (IN_W + LSH) : OUT_W;
  // Two guard bits so the aligned value plus accumulator can never wrap.
  localparam int W    = BASE + 2;
  localparam logic signed [W-1:0] HI = W'(sat_max(OUT_W));
  localparam logic signed [W-1:0] LO = W'(sat_min(OUT_W));

  logic signed [W-1:0] prod_x;
  logic signed [W-1:0] aligned;
  logic signed [W-1:0] acc_x;
  logic signed [W-1:0] sum;

  always_comb begin
    prod_x  = W'(prod);
    aligned = (prod_x <<< LSH) >>> RSH;
    acc_x   = add_acc ? W'(acc) : '0;
    sum     = aligned + acc_x;
    hit     = 1'b0;
    res     = sum[OUT_W-1:0];
    if (sum > HI) begin
      hit = 1'b1;
      res = HI[OUT_W-1:0];
    end else if (sum < LO) begin
      hit = 1'b1;
      res = LO[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/mac_pipe_real.sv
// N-lane fixed-point multiply / accumulate with sticky per-lane saturation flags.
// Latency PIPE_DEPTH enabled cycles, throughput 1; no backpressure, cke freezes everything.
module mac_pipe_real
  import mac_pipe_real_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int PIPE_DEPTH = 2,
  parameter int a_width    = 16,
  parameter int a_exponent = -8,
  parameter int b_width    = 16,
  parameter int b_exponent = -8,
  parameter int c_width    = 24,
  parameter int c_exponent = -12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cke,
  input  logic                      mode,
  input  logic                      clr,
  input  logic                      in_valid,
  input  logic [N_CH*a_width-1:0]   a,
  input  logic [N_CH*b_width-1:0]   b,
  output logic                      out_valid,
  output logic [N_CH*c_width-1:0]   c,
  output logic [N_CH-1:0]           sat
);

  localparam int P_W   = a_width + b_width;
  localparam int SHIFT = align_shift(a_exponent, b_exponent, c_exponent);

  logic                    tail_vld;
  logic                    tail_clr;
  logic                    tail_mode;
  logic [N_CH*a_width-1:0] tail_a;
  logic [N_CH*b_width-1:0] tail_b;
  logic [N_CH*c_width-1:0] acc;

  // Delay line ahead of the compute stage, so the accumulator sees samples in order, one per cycle.
  if (PIPE_DEPTH > 1) begin : g_dly
    localparam int ND = PIPE_DEPTH - 1;
    logic [ND-1:0]           dly_vld;
    logic [ND-1:0]           dly_clr;
    logic [ND-1:0]           dly_mode;
    logic [N_CH*a_width-1:0] dly_a [ND];
    logic [N_CH*b_width-1:0] dly_b [ND];

    always_ff @(posedge clk) begin
      if (rst) begin
        dly_vld <= '0;
        dly_clr <= '0;
      end else if (cke) begin
        dly_vld[0]  <= in_valid;
        dly_clr[0]  <= clr;
        dly_mode[0] <= mode;
        dly_a[0]    <= a;
        dly_b[0]    <= b;
        for (int i = 1; i < ND; i++) begin
          dly_vld[i]  <= dly_vld[i-1];
          dly_clr[i]  <= dly_clr[i-1];
          dly_mode[i] <= dly_mode[i-1];
          dly_a[i]    <= dly_a[i-1];
          dly_b[i]    <= dly_b[i-1];
        end
      end
    end

    assign tail_vld  = dly_vld[ND-1];
    assign tail_clr  = dly_clr[ND-1];
    assign tail_mode = dly_mode[ND-1];
    assign tail_a    = dly_a[ND-1];
    assign tail_b    = dly_b[ND-1];
  end else begin : g_direct
    assign tail_vld  = in_valid;
    assign tail_clr  = clr;
    assign tail_mode = mode;
    assign tail_a    = a;
    assign tail_b    = b;
  end

  logic signed [c_width-1:0] lane_res [N_CH];
  logic                      lane_hit [N_CH];
  logic                      add_acc;

  assign add_acc = (tail_mode != MODE_MUL) && !tail_clr;

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    logic signed [a_width-1:0] a_l;
    logic signed [b_width-1:0] b_l;
    logic signed [P_W-1:0]     prod;

    assign a_l  = tail_a[k*a_width +: a_width];
    assign b_l  = tail_b[k*b_width +: b_width];
    assign prod = P_W'(a_l) * P_W'(b_l);

    real_align_sat #(
      .IN_W  (P_W),
      .SHIFT (SHIFT),
      .OUT_W (c_width)
    ) u_align_sat (
      .prod    (prod),
      .acc     (acc[k*c_width +: c_width]),
      .add_acc (add_acc),
      .res     (lane_res[k]),
      .hit     (lane_hit[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      c         <= '0;
      acc       <= '0;
      sat       <= '0;
    end else if (cke) begin
      out_valid <= tail_vld;
      for (int k = 0; k < N_CH; k++) begin
        if (tail_vld) begin
          c[k*c_width +: c_width] <= lane_res[k];
          if (tail_mode == MODE_ACC || tail_clr) begin
            acc[k*c_width +: c_width] <= lane_res[k];
          end
          sat[k] <= (sat[k] & ~tail_clr) | lane_hit[k];
        end else if (tail_clr) begin
          acc[k*c_width +: c_width] <= '0;
          sat[k]                    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_pipe_real.sv
// Self-checking bench for mac_pipe_real at default parameters: vector table plus
// hand sequences for reset, clock-enable stalls and clear-without-valid.
module tb_mac_pipe_real;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cke;
  logic        mode;
  logic        clr;
  logic        in_valid;
  logic [63:0] a;
  logic [63:0] b;
  logic        out_valid;
  logic [95:0] c;
  logic [3:0]  sat;

  mac_pipe_real #(
    .N_CH(4), .PIPE_DEPTH(DEPTH),
    .a_width(16), .a_exponent(-8),
    .b_width(16), .b_exponent(-8),
    .c_width(24), .c_exponent(-12)
  ) dut (
    .clk(clk), .rst(rst), .cke(cke), .mode(mode), .clr(clr),
    .in_valid(in_valid), .a(a), .b(b),
    .out_valid(out_valid), .c(c), .sat(sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic        clr;
    logic [63:0] a;
    logic [63:0] b;
    logic [95:0] c;
    logic [3:0]  sat;
  } vec_t;

  typedef struct {
    logic [95:0] c;
    logic [3:0]  sat;
    int          due;
  } exp_t;

  vec_t tbl [11];
  exp_t sb [$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   ecnt         = 0;
  int   prev_ecnt    = 0;

  function automatic logic [63:0] rep16(input logic [15:0] v);
    return {4{v}};
  endfunction

  function automatic logic [95:0] rep24(input logic [23:0] v);
    return {4{v}};
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Enabled-edge counter: the time base for latency checks.
  always @(posedge clk) begin
    if (!rst && cke) ecnt <= ecnt + 1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (ecnt != prev_ecnt && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_out: actual out_valid=1 c=%h required no output", c);
      end else begin
        e = sb.pop_front();
        chk("c", c, e.c);
        chk("sat", 96'(sat), 96'(e.sat));
        chk("latency", 96'(ecnt), 96'(e.due));
      end
    end
    prev_ecnt = ecnt;
  end

  task automatic idle();
    @(negedge clk);
    cke = 1'b1; in_valid = 1'b0; clr = 1'b0; mode = 1'b0;
  endtask

  task automatic send(input logic m, input logic cl, input logic [63:0] av, input logic [63:0] bv,
                      input logic [95:0] ec, input logic [3:0] es);
    exp_t e;
    @(negedge clk);
    cke = 1'b1; in_valid = 1'b1; mode = m; clr = cl; a = av; b = bv;
    e.c = ec; e.sat = es; e.due = ecnt + DEPTH;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) idle();
    idle();
    chk("drain_empty", 96'(sb.size()), 96'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b0, 1'b0, rep16(16'd315),   rep16(16'd1167),  rep24(24'd22975),   4'h0};
    tbl[1]  = '{1'b0, 1'b0, rep16(16'd32765), rep16(16'd32765), rep24(24'h7FFFFF),  4'hF};
    tbl[2]  = '{1'b0, 1'b0, rep16(16'd256),   rep16(16'd256),   rep24(24'd4096),    4'hF};
    tbl[3]  = '{1'b1, 1'b1, rep16(16'd256),   rep16(16'd512),   rep24(24'd8192),    4'h0};
    tbl[4]  = '{1'b1, 1'b0, rep16(16'd256),   rep16(16'd512),   rep24(24'd16384),   4'h0};
    tbl[5]  = '{1'b1, 1'b0, rep16(16'd256),   rep16(16'd512),   rep24(24'd24576),   4'h0};
    tbl[6]  = '{1'b0, 1'b0, {16'd256, 16'hFE80, 16'd256, 16'd256},
                            {16'd256, 16'd128,  16'd256, 16'd256},
                            {24'd4096, 24'hFFF400, 24'd4096, 24'd4096}, 4'h0};
    tbl[7]  = '{1'b1, 1'b0, rep16(16'd256),   rep16(16'd256),   rep24(24'd28672),   4'h0};
    tbl[8]  = '{1'b0, 1'b0, rep16(16'hFFFF),  rep16(16'd1),     rep24(24'hFFFFFF),  4'h0};
    tbl[9]  = '{1'b0, 1'b0, rep16(16'h8000),  rep16(16'h7FFF),  rep24(24'h800000),  4'hF};
    tbl[10] = '{1'b1, 1'b1, rep16(16'h7FFF),  rep16(16'h7FFF),  rep24(24'h7FFFFF),  4'hF};

    rst = 1'b1; cke = 1'b1; mode = 1'b0; clr = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", 96'(out_valid), 96'd0);
    chk("reset_c", c, 96'd0);
    chk("reset_sat", 96'(sat), 96'd0);
    rst = 1'b0;

    // Back-to-back vectors: multiply, saturation, accumulate, lane independence, floor, clear.
    for (int i = 0; i < 11; i++) send(tbl[i].mode, tbl[i].clr, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].sat);
    drain();

    // Reset with cke low and two samples in flight: both must vanish.
    @(negedge clk);
    cke = 1'b1; in_valid = 1'b1; mode = 1'b0; clr = 1'b0; a = rep16(16'd256); b = rep16(16'd256);
    @(negedge clk);
    rst = 1'b1; cke = 1'b0; in_valid = 1'b1; a = rep16(16'd512);
    @(negedge clk);
    chk("rst_out_valid", 96'(out_valid), 96'd0);
    chk("rst_c", c, 96'd0);
    chk("rst_sat", 96'(sat), 96'd0);
    rst = 1'b0; cke = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_flushed", 96'(out_valid), 96'd0);
    send(1'b0, 1'b0, rep16(16'd256), rep16(16'd256), rep24(24'd4096), 4'h0);
    drain();

    // Three-cycle clock-enable stall in the middle of an accumulate burst.
    send(1'b1, 1'b1, rep16(16'd256), rep16(16'd512), rep24(24'd8192), 4'h0);
    send(1'b1, 1'b0, rep16(16'd256), rep16(16'd512), rep24(24'd16384), 4'h0);
    @(negedge clk);
    cke = 1'b0; in_valid = 1'b1; a = rep16(16'h1234); b = rep16(16'h0777);
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      chk("stall_c", c, rep24(24'd8192));
      chk("stall_out_valid", 96'(out_valid), 96'd1);
    end
    send(1'b1, 1'b0, rep16(16'd256), rep16(16'd512), rep24(24'd24576), 4'h0);
    drain();

    // Accumulator saturates, then a clear without valid zeroes it and drops sat.
    send(1'b1, 1'b0, rep16(16'h7FFF), rep16(16'h7FFF), rep24(24'h7FFFFF), 4'hF);
    @(negedge clk);
    cke = 1'b1; in_valid = 1'b0; clr = 1'b1; mode = 1'b1;
    send(1'b1, 1'b0, rep16(16'd256), rep16(16'd512), rep24(24'd8192), 4'h0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mac_pipe_real.md
MAC_PIPE_REAL -- requirements
Module: mac_pipe_real

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- N_CH, 4: number of independent channels
- PIPE_DEPTH, 2: input-to-output latency in enabled cycles; legal range 1..8
- a_width, 16; a_exponent, -8: fixed-point format of input a
- b_width, 16; b_exponent, -8: fixed-point format of input b
- c_width, 24; c_exponent, -12: fixed-point format of output c
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock
- rst, in, 1: synchronous, active-high reset
- cke, in, 1: clock enable; 0 freezes all state
- mode, in, 1: 0 = multiply, 1 = accumulate
- clr, in, 1: clear accumulators; sampled with in_valid
- in_valid, in, 1: a/b lanes valid this cycle
- a, in, N_CH*a_width: signed a lanes, lane k at bits [k*a_width +: a_width]
- b, in, N_CH*b_width: signed b lanes, same lane packing as a
- out_valid, out, 1: c lanes valid
- c, out, N_CH*c_width: signed result lanes
- sat, out, N_CH: sticky per-lane saturation flag
REQ-003 One clock; reset SHALL be synchronous and active-high.

Function
REQ-004 Each lane SHALL form the full-precision product a*b, width a_width+b_width, exponent a_exponent+b_exponent.
REQ-005 Alignment SHALL shift by d = (a_exponent+b_exponent) - c_exponent: left if d>0; arithmetic right if d<0 (floor, toward -inf).
REQ-006 The aligned value SHALL saturate to [-2^(c_width-1), 2^(c_width-1)-1].
- Saturation SHALL set that lane's sat bit.
- The sat bit SHALL hold until rst or an accepted clr.
REQ-007 mode=0: c SHALL equal the saturated aligned product.
REQ-008 mode=1: per lane, acc <= sat(acc + aligned product) on each accepted input; c SHALL be the new acc value.
REQ-009 clr=1 with in_valid=1 SHALL load acc with the current product; clr=1 with in_valid=0 SHALL zero acc and produce no out_valid.
REQ-010 Accepted sample = in_valid & cke; its result SHALL appear with out_valid exactly PIPE_DEPTH enabled cycles later.
REQ-011 mode and clr SHALL be pipelined with their sample; a mode change mid-stream SHALL apply per sample.
REQ-012 cke=0 SHALL hold all pipeline registers, acc, c, out_valid and sat.
REQ-013 Back-to-back samples SHALL be accepted every enabled cycle (throughput 1).
REQ-014 Accumulator feedback SHALL be sequenced so consecutive accumulate samples never read a stale acc.

Reset
REQ-015 rst=1 at a clk edge SHALL clear, regardless of cke:
- all pipeline valids
- out_valid=0, c=0, acc=0, sat=0
REQ-016 rst mid-operation SHALL discard in-flight samples; the first accepted input after rst SHALL appear PIPE_DEPTH enabled cycles later.

Structure
REQ-017 A package mac_pipe_real_pkg SHALL hold:
- mode encoding constants
- a function for saturation bounds by width
- a constant-evaluable align-shift helper
REQ-018 One per-lane sub-module real_align_sat SHALL perform shift plus saturate, instantiated N_CH times via generate.
REQ-019 Pipeline stages SHALL be a parametrised register array; no latches; no real-typed datapath.

Verification (defaults)
REQ-020 Directed scenarios:
- mode=0, a=1.23 (raw 315), b=4.56 (raw 1167), all lanes -> c lane raw 22975 after 2 cycles, sat=0.
- mode=0, a=b=127.99 (raw 32765) -> c raw 8388607, sat=1, sat still 1 after next in-range sample.
- mode=1, clr on first of three samples a=1.0, b=2.0 -> c raw 8192, 16384, 24576 on consecutive cycles.
- cke=0 for 3 cycles mid-stream -> outputs frozen, no sample lost or duplicated, latency counted in enabled cycles.
- rst asserted with 2 samples in flight -> no out_valid for those samples; next sample raw 4096 (1.0*1.0) appears 2 cycles later.
- Per-lane independence: lane 2 negative a=-1.5, b=0.5 -> lane 2 raw -3072, other lanes unaffected.
